// File: rtl/addsub_seq_pkg.sv
// Shared types for the iterative adder/subtractor: op codes, FSM states, modes.
// ADDSUB_ABS_EN enables the abs-difference SWAP pass.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ABS = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef ADDSUB_ABS_EN
    S_SWAP = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ABS = 2'd2
  } mode_e;

  // Reserved op folds into add; abs collapses to sub when the swap pass is absent.
  function automatic mode_e decode_op(op_e op);
    case (op)
      OP_SUB:  return MODE_SUB;
`ifdef ADDSUB_ABS_EN
      OP_ABS:  return MODE_ABS;
`else
      OP_ABS:  return MODE_SUB;
`endif
      default: return MODE_ADD;
    endcase
  endfunction

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Request/result bundle for addsub_seq; master issues start/op/a/b, slave returns results.
interface addsub_seq_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, s, co, ov, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, s, co, ov, zero
  );
endinterface

// File: rtl/addsub_seq_adder_chunk.sv
// Combinational ripple-carry slice of CHUNK full adders; c_msb is the carry
// into the top bit so the caller can form signed overflow.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic c;

  always_comb begin
    c     = ci;
    s     = '0;
    c_msb = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub/abs-diff unit: CHUNK bits per cycle, start/done handshake.
// Define ADDSUB_ABS_EN to enable |a-b| via a second (SWAP) pass.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  addsub_seq_if.slave bus
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = cnt_width(N);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] ca, cb, csum;
  logic             cco, cmsb;
  logic [WIDTH-1:0] res_next;
  logic             last;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (ca),
    .b    (cb),
    .ci   (carry_q),
    .s    (csum),
    .co   (cco),
    .c_msb(cmsb)
  );

  always_comb begin
    ca = a_q[CHUNK-1:0];
    cb = b_q[CHUNK-1:0];
`ifdef ADDSUB_ABS_EN
    if (state_q == S_SWAP) begin
      ca = b_q[CHUNK-1:0];
      cb = a_q[CHUNK-1:0];
    end
`endif
    if (mode_q != MODE_ADD) cb = ~cb;
    res_next = (res_q >> CHUNK) | (WIDTH'(csum) << (WIDTH - CHUNK));
    last     = (cnt_q == CW'(N - 1));
  end

  // Operands rotate rather than shift, so after one pass they are intact for the swap pass.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          mode_d  = decode_op(op_e'(bus.op));
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = (decode_op(op_e'(bus.op)) != MODE_ADD);
          cnt_d   = '0;
          res_d   = '0;
          s_d     = '0;
          co_d    = 1'b0;
          ov_d    = 1'b0;
          zero_d  = 1'b0;
        end
      end

      S_RUN: begin
        a_d     = (a_q >> CHUNK) | (a_q << (WIDTH - CHUNK));
        b_d     = (b_q >> CHUNK) | (b_q << (WIDTH - CHUNK));
        res_d   = res_next;
        carry_d = cco;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          s_d     = res_next;
          co_d    = cco;
          ov_d    = (mode_q == MODE_ABS) ? 1'b0 : (cmsb ^ cco);
          zero_d  = (res_next == '0);
`ifdef ADDSUB_ABS_EN
          if (mode_q == MODE_ABS && !cco) begin
            state_d = S_SWAP;
            carry_d = 1'b1;
            res_d   = '0;
            s_d     = s_q;
            co_d    = co_q;
            ov_d    = ov_q;
            zero_d  = zero_q;
          end
`endif
        end
      end

`ifdef ADDSUB_ABS_EN
      S_SWAP: begin
        a_d     = (a_q >> CHUNK) | (a_q << (WIDTH - CHUNK));
        b_d     = (b_q >> CHUNK) | (b_q << (WIDTH - CHUNK));
        res_d   = res_next;
        carry_d = cco;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          s_d     = res_next;
          co_d    = 1'b0;
          ov_d    = 1'b0;
          zero_d  = (res_next == '0);
        end
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ov   = ov_q;
  assign bus.zero = zero_q;

endmodule
